// File: rtl/sprite_anim_renderer.sv
// Sprite renderer: box test + frame-offset address into a synchronous sprite ROM,
// transparency-aware colour output, and a divided multi-mode frame animator.
module sprite_anim_renderer #(
   parameter int unsigned     SPR_W       = 10,
   parameter int unsigned     SPR_H       = 12,
   parameter int unsigned     NUM_FRAMES  = 3,
   parameter int unsigned     AW          = 9,
   parameter int unsigned     FW          = 2,
   parameter int unsigned     CW          = 3,
   parameter logic [CW-1:0]   TRANSPARENT = '0,
   parameter int unsigned     DIV         = 4,
   parameter int unsigned     ROM_LAT     = 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          frameClk,
   input  logic          enable,
   input  logic [1:0]    mode,
   input  logic [FW-1:0] first_frame,
   input  logic [FW-1:0] last_frame,
   input  logic [7:0]    x,
   input  logic [7:0]    y,
   input  logic [7:0]    spr_left,
   input  logic [7:0]    spr_top,
   output logic [AW-1:0] rom_addr,
   input  logic [CW-1:0] rom_q,
   output logic [CW-1:0] color,
   output logic          pixel_valid,
   output logic [FW-1:0] frame_idx,
   output logic          anim_done
);

   typedef enum logic [1:0] {
      MODE_HOLD     = 2'd0,
      MODE_LOOP     = 2'd1,
      MODE_ONESHOT  = 2'd2,
      MODE_PINGPONG = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   localparam int unsigned   DW           = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned   CFGW         = 2 + 2 * FW;
   localparam logic [DW-1:0] DIV_RELOAD   = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_ONE      = DW'(1);
   localparam logic [FW-1:0] FRAME_ONE    = FW'(1);
   localparam logic [FW:0]   NUM_FRAMES_W = (FW + 1)'(NUM_FRAMES);
   localparam logic [AW-1:0] FRAME_WORDS  = AW'(SPR_W * SPR_H);
   localparam logic [AW-1:0] SPR_W_A      = AW'(SPR_W);
   localparam logic [8:0]    SPR_W_9      = 9'(SPR_W);
   localparam logic [8:0]    SPR_H_9      = 9'(SPR_H);

   // ---------------- animation state ----------------
   logic [FW-1:0]   frame_idx_q, frame_idx_d;
   logic [DW-1:0]   div_cnt_q,   div_cnt_d;
   dir_e            dir_q,       dir_d;
   logic            anim_done_q, anim_done_d;
   logic            handled_q,   handled_d;
   logic [CFGW-1:0] cfg_q,       cfg_d;

   // ---------------- pixel pipeline state ----------------
   logic            s0_valid_q,  s0_valid_d;
   logic [7:0]      x_s0_q,      x_s0_d;
   logic [7:0]      y_s0_q,      y_s0_d;
   logic [7:0]      left_s0_q,   left_s0_d;
   logic [7:0]      top_s0_q,    top_s0_d;
   logic [FW-1:0]   frame_s0_q,  frame_s0_d;
   logic [AW-1:0]   rom_addr_q,  rom_addr_d;
   logic [ROM_LAT:0] inbox_q,    inbox_d;
   logic [CW-1:0]   color_q,     color_d;
   logic            pixel_valid_q, pixel_valid_d;

   logic            tick;
   logic            restart;
   logic            degenerate;
   mode_e           eff_mode;
   logic [8:0]      x9, y9, left9, top9;
   logic [8:0]      dx, dy;
   logic            in_box;

   assign tick       = frameClk & ~handled_q & enable;
   assign restart    = ({mode, first_frame, last_frame} != cfg_q);
   assign degenerate = (last_frame < first_frame) || ({1'b0, last_frame} >= NUM_FRAMES_W);
   assign eff_mode   = degenerate ? MODE_HOLD : mode_e'(mode);

   always_comb begin
      cfg_d       = {mode, first_frame, last_frame};
      handled_d   = frameClk;
      frame_idx_d = frame_idx_q;
      div_cnt_d   = div_cnt_q;
      dir_d       = dir_q;
      anim_done_d = anim_done_q;

      // A config change swallows any tick landing in the same cycle.
      if (restart) begin
         frame_idx_d = first_frame;
         div_cnt_d   = DIV_RELOAD;
         dir_d       = DIR_UP;
         anim_done_d = 1'b0;
      end else if (tick) begin
         if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - DIV_ONE;
         end else begin
            div_cnt_d = DIV_RELOAD;
            unique case (eff_mode)
               MODE_HOLD: begin
                  frame_idx_d = first_frame;
               end
               MODE_LOOP: begin
                  frame_idx_d = (frame_idx_q >= last_frame) ? first_frame : frame_idx_q + FRAME_ONE;
               end
               MODE_ONESHOT: begin
                  if (frame_idx_q < last_frame) begin
                     frame_idx_d = frame_idx_q + FRAME_ONE;
                  end
                  anim_done_d = (frame_idx_d == last_frame);
               end
               MODE_PINGPONG: begin
                  if (first_frame != last_frame) begin
                     if (dir_q == DIR_UP) begin
                        if (frame_idx_q >= last_frame) begin
                           dir_d       = DIR_DOWN;
                           frame_idx_d = frame_idx_q - FRAME_ONE;
                        end else begin
                           frame_idx_d = frame_idx_q + FRAME_ONE;
                        end
                     end else begin
                        if (frame_idx_q <= first_frame) begin
                           dir_d       = DIR_UP;
                           frame_idx_d = frame_idx_q + FRAME_ONE;
                        end else begin
                           frame_idx_d = frame_idx_q - FRAME_ONE;
                        end
                     end
                  end
               end
               default: begin
                  frame_idx_d = first_frame;
               end
            endcase
         end
      end
   end

   // Box test runs on 9-bit sums so a sprite near x=255 never wraps onto x=0.
   assign x9     = {1'b0, x_s0_q};
   assign y9     = {1'b0, y_s0_q};
   assign left9  = {1'b0, left_s0_q};
   assign top9   = {1'b0, top_s0_q};
   assign dx     = x9 - left9;
   assign dy     = y9 - top9;
   assign in_box = s0_valid_q &&
                   (x9 >= left9) && (x9 < left9 + SPR_W_9) &&
                   (y9 >= top9)  && (y9 < top9 + SPR_H_9);

   always_comb begin
      s0_valid_d = 1'b1;
      x_s0_d     = x;
      y_s0_d     = y;
      left_s0_d  = spr_left;
      top_s0_d   = spr_top;
      frame_s0_d = frame_idx_q;

      rom_addr_d = '0;
      if (in_box) begin
         rom_addr_d = AW'(frame_s0_q) * FRAME_WORDS + AW'(dx) + AW'(dy) * SPR_W_A;
      end

      inbox_d       = {inbox_q[ROM_LAT-1:0], in_box};
      pixel_valid_d = inbox_q[ROM_LAT] && (rom_q != TRANSPARENT);
      color_d       = pixel_valid_d ? rom_q : '0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         frame_idx_q   <= first_frame;
         div_cnt_q     <= DIV_RELOAD;
         dir_q         <= DIR_UP;
         anim_done_q   <= 1'b0;
         handled_q     <= 1'b0;
         cfg_q         <= {mode, first_frame, last_frame};
         s0_valid_q    <= 1'b0;
         x_s0_q        <= '0;
         y_s0_q        <= '0;
         left_s0_q     <= '0;
         top_s0_q      <= '0;
         frame_s0_q    <= '0;
         rom_addr_q    <= '0;
         inbox_q       <= '0;
         color_q       <= '0;
         pixel_valid_q <= 1'b0;
      end else begin
         frame_idx_q   <= frame_idx_d;
         div_cnt_q     <= div_cnt_d;
         dir_q         <= dir_d;
         anim_done_q   <= anim_done_d;
         handled_q     <= handled_d;
         cfg_q         <= cfg_d;
         s0_valid_q    <= s0_valid_d;
         x_s0_q        <= x_s0_d;
         y_s0_q        <= y_s0_d;
         left_s0_q     <= left_s0_d;
         top_s0_q      <= top_s0_d;
         frame_s0_q    <= frame_s0_d;
         rom_addr_q    <= rom_addr_d;
         inbox_q       <= inbox_d;
         color_q       <= color_d;
         pixel_valid_q <= pixel_valid_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign color       = color_q;
   assign pixel_valid = pixel_valid_q;
   assign frame_idx   = frame_idx_q;
   assign anim_done   = anim_done_q;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: animation sequences from constant tables,
// pixel path checked through an expected-result queue against a 1-clock ROM.
module tb_sprite_anim_renderer;

   localparam int DIV   = 4;
   localparam int SPR_W = 10;
   localparam int SPR_H = 12;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       frameClk = 1'b0;
   logic       enable = 1'b1;
   logic [1:0] mode = 2'd0;
   logic [1:0] first_frame = 2'd0;
   logic [1:0] last_frame = 2'd0;
   logic [7:0] x = 8'd0, y = 8'd0, spr_left = 8'd0, spr_top = 8'd0;
   logic [8:0] rom_addr;
   logic [2:0] rom_q = 3'd0;
   logic [2:0] color;
   logic       pixel_valid;
   logic [1:0] frame_idx;
   logic       anim_done;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [2:0] rom_mem [0:511];

   typedef struct {
      int px;
      int py;
      int l;
      int t;
   } pix_t;

   pix_t       tbl[$];
   int         aq[$];
   logic [3:0] cq[$];

   sprite_anim_renderer #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(3), .AW(9), .FW(2), .CW(3),
      .TRANSPARENT(3'd0), .DIV(DIV), .ROM_LAT(1)
   ) dut (
      .clk(clk), .resetn(resetn), .frameClk(frameClk), .enable(enable), .mode(mode),
      .first_frame(first_frame), .last_frame(last_frame), .x(x), .y(y),
      .spr_left(spr_left), .spr_top(spr_top), .rom_addr(rom_addr), .rom_q(rom_q),
      .color(color), .pixel_valid(pixel_valid), .frame_idx(frame_idx), .anim_done(anim_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_q <= rom_mem[rom_addr];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic bit in_box(input int px, input int py, input int l, input int t);
      return (px >= l) && (px < l + SPR_W) && (py >= t) && (py < t + SPR_H);
   endfunction

   task automatic do_tick(input int hold);
      @(negedge clk) frameClk = 1'b1;
      repeat (hold) @(negedge clk);
      frameClk = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_cfg(input logic [1:0] m, input logic [1:0] f, input logic [1:0] l);
      @(negedge clk);
      mode = m; first_frame = f; last_frame = l;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset(input logic [1:0] exp_frame);
      @(negedge clk) resetn = 1'b0;
      @(negedge clk);
      total_cnt++; if (frame_idx !== exp_frame) $display("FAIL reset_frame got %0d want %0d", frame_idx, exp_frame); else pass_cnt++;
      total_cnt++; if (anim_done !== 1'b0) $display("FAIL reset_done got %0b want 0", anim_done); else pass_cnt++;
      total_cnt++; if (color !== 3'd0) $display("FAIL reset_color got %0d want 0", color); else pass_cnt++;
      total_cnt++; if (pixel_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", pixel_valid); else pass_cnt++;
      total_cnt++; if (rom_addr !== 9'd0) $display("FAIL reset_addr got %0d want 0", rom_addr); else pass_cnt++;
      @(negedge clk) resetn = 1'b1;
   endtask

   task automatic test_loop;
      logic [1:0] ef;
      set_cfg(2'd1, 2'd1, 2'd2);
      total_cnt++; if (frame_idx !== 2'd1) $display("FAIL loop_start got %0d want 1", frame_idx); else pass_cnt++;
      for (int t = 1; t <= 8; t++) begin
         do_tick((t == 1) ? 10 : 1);
         ef = 2'(1 + ((t / DIV) % 2));
         total_cnt++; if (frame_idx !== ef) $display("FAIL loop_tick%0d got %0d want %0d", t, frame_idx, ef); else pass_cnt++;
      end
      enable = 1'b0;
      repeat (3) do_tick(1);
      total_cnt++; if (frame_idx !== 2'd1) $display("FAIL loop_paused got %0d want 1", frame_idx); else pass_cnt++;
      // strobe rises during the pause and is still high when enable returns
      @(negedge clk) frameClk = 1'b1;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      frameClk = 1'b0;
      @(negedge clk);
      repeat (DIV - 1) do_tick(1);
      total_cnt++; if (frame_idx !== 2'd1) $display("FAIL loop_resume_pre got %0d want 1", frame_idx); else pass_cnt++;
      do_tick(1);
      total_cnt++; if (frame_idx !== 2'd2) $display("FAIL loop_resume got %0d want 2", frame_idx); else pass_cnt++;
   endtask

   task automatic stream_pixels(input int f);
      int n;
      int ea;
      logic [3:0] ec;
      n = tbl.size();
      for (int i = 0; i < n + 4; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            ea = aq.pop_front();
            total_cnt++; if (rom_addr !== 9'(ea)) $display("FAIL pix_addr[%0d] got %0d want %0d", i - 2, rom_addr, ea); else pass_cnt++;
         end
         if (i >= 4) begin
            ec = cq.pop_front();
            total_cnt++; if ({pixel_valid, color} !== ec) $display("FAIL pix_color[%0d] got v=%0b c=%0d want v=%0b c=%0d", i - 4, pixel_valid, color, ec[3], ec[2:0]); else pass_cnt++;
         end
         if (i < n) begin
            x = 8'(tbl[i].px); y = 8'(tbl[i].py); spr_left = 8'(tbl[i].l); spr_top = 8'(tbl[i].t);
            if (in_box(tbl[i].px, tbl[i].py, tbl[i].l, tbl[i].t)) begin
               ea = f * SPR_W * SPR_H + (tbl[i].px - tbl[i].l) + (tbl[i].py - tbl[i].t) * SPR_W;
               ec = (rom_mem[ea] != 3'd0) ? {1'b1, rom_mem[ea]} : 4'd0;
            end else begin
               ea = 0;
               ec = 4'd0;
            end
            aq.push_back(ea);
            cq.push_back(ec);
         end
      end
      tbl.delete();
   endtask

   task automatic test_pixels;
      set_cfg(2'd0, 2'd2, 2'd2);
      total_cnt++; if (frame_idx !== 2'd2) $display("FAIL pix_frame got %0d want 2", frame_idx); else pass_cnt++;
      tbl.push_back('{20, 100, 20, 100});
      tbl.push_back('{29, 111, 20, 100});
      tbl.push_back('{28, 111, 20, 100});
      tbl.push_back('{30, 111, 20, 100});
      tbl.push_back('{19, 100, 20, 100});
      tbl.push_back('{29, 112, 20, 100});
      tbl.push_back('{3, 40, 250, 40});
      tbl.push_back('{255, 40, 250, 40});
      tbl.push_back('{255, 51, 250, 40});
      tbl.push_back('{255, 52, 250, 40});
      tbl.push_back('{249, 40, 250, 40});
      tbl.push_back('{0, 40, 250, 40});
      stream_pixels(2);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 24; i++)
         tbl.push_back('{$urandom_range(15, 35), $urandom_range(95, 115), 20, 100});
      stream_pixels(2);
   endtask

   task automatic test_oneshot;
      logic [1:0] ef;
      logic       ed;
      set_cfg(2'd2, 2'd0, 2'd2);
      total_cnt++; if (frame_idx !== 2'd0 || anim_done !== 1'b0) $display("FAIL oneshot_start got f=%0d d=%0b want f=0 d=0", frame_idx, anim_done); else pass_cnt++;
      for (int s = 1; s <= 4; s++) begin
         repeat (DIV) do_tick(1);
         ef = (s >= 2) ? 2'd2 : 2'(s);
         ed = (s >= 2);
         total_cnt++; if (frame_idx !== ef || anim_done !== ed) $display("FAIL oneshot_step%0d got f=%0d d=%0b want f=%0d d=%0b", s, frame_idx, anim_done, ef, ed); else pass_cnt++;
      end
   endtask

   task automatic test_restart_tick;
      @(negedge clk);
      mode = 2'd1;
      frameClk = 1'b1;
      @(negedge clk);
      total_cnt++; if (frame_idx !== 2'd0 || anim_done !== 1'b0) $display("FAIL restart got f=%0d d=%0b want f=0 d=0", frame_idx, anim_done); else pass_cnt++;
      @(negedge clk) frameClk = 1'b0;
      @(negedge clk);
      repeat (DIV - 1) do_tick(1);
      total_cnt++; if (frame_idx !== 2'd0) $display("FAIL restart_dropped got %0d want 0", frame_idx); else pass_cnt++;
      do_tick(1);
      total_cnt++; if (frame_idx !== 2'd1) $display("FAIL restart_step got %0d want 1", frame_idx); else pass_cnt++;
   endtask

   task automatic test_pingpong;
      logic [1:0] seq [6];
      seq = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
      set_cfg(2'd3, 2'd0, 2'd2);
      for (int s = 0; s < 6; s++) begin
         repeat (DIV) do_tick(1);
         total_cnt++; if (frame_idx !== seq[s]) $display("FAIL pingpong_step%0d got %0d want %0d", s + 1, frame_idx, seq[s]); else pass_cnt++;
      end
      set_cfg(2'd3, 2'd1, 2'd3);
      repeat (2 * DIV) do_tick(1);
      total_cnt++; if (frame_idx !== 2'd1) $display("FAIL pingpong_oob got %0d want 1", frame_idx); else pass_cnt++;
      set_cfg(2'd1, 2'd2, 2'd1);
      repeat (2 * DIV) do_tick(1);
      total_cnt++; if (frame_idx !== 2'd2) $display("FAIL loop_inverted got %0d want 2", frame_idx); else pass_cnt++;
      set_cfg(2'd2, 2'd1, 2'd1);
      repeat (DIV) do_tick(1);
      total_cnt++; if (frame_idx !== 2'd1 || anim_done !== 1'b1) $display("FAIL oneshot_single got f=%0d d=%0b want f=1 d=1", frame_idx, anim_done); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      set_cfg(2'd2, 2'd0, 2'd2);
      repeat (2 * DIV) do_tick(1);
      total_cnt++; if (anim_done !== 1'b1) $display("FAIL mid_pre_done got %0b want 1", anim_done); else pass_cnt++;
      test_reset(2'd0);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) rom_mem[i] = 3'($urandom_range(0, 7));
      rom_mem[240] = 3'd3;
      rom_mem[245] = 3'd6;
      rom_mem[358] = 3'd0;
      rom_mem[359] = 3'd5;
      test_reset(2'd0);
      test_loop();
      test_pixels();
      test_back_to_back();
      test_oneshot();
      test_restart_tick();
      test_pingpong();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
